// File: rtl/corescore_uart_rx.sv
// corescore_uart_rx: UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Received bytes go to a single holding register on an AXI4-Stream-style master port.
module corescore_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 278,
    parameter logic [7:0]  EOL_BYTE     = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitn_q, bitn_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       tdata_q, tdata_d;
    logic             tlast_q, tlast_d;
    logic             tvalid_q, tvalid_d;
    logic             ferr_q, ferr_d;
    logic             overrun_q, overrun_d;
    logic             bad_par;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bitn_d    = bitn_q;
        shift_d   = shift_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q && !i_tready;
        ferr_d    = 1'b0;
        overrun_d = overrun_q;
        bad_par   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
        bad_par   = ^{shift_q, par_q};
`endif
        case (state_q)
            IDLE: if (!rx_s_q) state_d = START;
            START: begin
                if (cnt_q == HALF_M1) begin
                    state_d = rx_s_q ? IDLE : DATA;
                    bitn_d  = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bitn_d  = bitn_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bitn_q == 3'd7) state_d = PARITY;
`else
                    if (bitn_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    par_d   = rx_s_q;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Completion is decided on the stop sample so results appear the next cycle.
                if (cnt_q == BIT_LAST) begin
                    state_d = rx_s_q ? IDLE : BREAK;
                    ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
                    perr_d  = bad_par;
`endif
                    if (rx_s_q && !bad_par) begin
                        if (tvalid_q && !i_tready) begin
                            overrun_d = 1'b1;
                        end else begin
                            tdata_d  = shift_q;
                            tlast_d  = (shift_q == EOL_BYTE);
                            tvalid_d = 1'b1;
                        end
                    end
                end
            end
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitn_q    <= '0;
            shift_q   <= '0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitn_q    <= bitn_d;
            shift_q   <= shift_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign o_tdata     = tdata_q;
    assign o_tlast     = tlast_q;
    assign o_tvalid    = tvalid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
